pfb_coef_loader: RTL
====================

PFB_COEF_LOADER -- requirements
Module: pfb_coef_loader

Interface
REQ-001 Parameter ADDR_W, default 7: coefficient RAM address width; the RAM depth is 2^ADDR_W.
REQ-002 Parameter DATA_W, default 25: coefficient word width.
REQ-003 clk  input  1  single clock; all logic SHALL be rising-edge.
REQ-004 sync_reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin a load.
REQ-006 num_taps  input  ADDR_W+1  coefficient count; sampled only on an accepted start.
REQ-007 s_axis_tvalid  input  1  coefficient beat valid.
REQ-008 s_axis_tdata  input  DATA_W  coefficient value.
REQ-009 s_axis_tlast  input  1  marks the final coefficient of the stream.
REQ-010 s_axis_tready  output  1  loader accepts a beat.
REQ-011 wea  output  1  RAM write enable, registered.
REQ-012 addra  output  ADDR_W  RAM write address, registered.
REQ-013 dia  output  DATA_W  RAM write data, registered.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse marking the end of a load.
REQ-016 err  output  1  sticky error flag; cleared by an accepted start or by sync_reset.

Function
REQ-017 The block SHALL implement the states IDLE, LOAD, DRAIN, ZERO and DONE.
REQ-018 IDLE: s_axis_tready=0.
- start with 1 <= num_taps <= 2^ADDR_W -> latch num_taps, clear err, clear the count, go to LOAD.
- start with num_taps outside that range -> set err, stay in IDLE, assert no done.
REQ-019 start SHALL be ignored in every state other than IDLE.
REQ-020 LOAD: s_axis_tready=1; a beat is accepted when tvalid and tready are both high.
REQ-021 Each accepted beat SHALL produce, on the next cycle, wea=1, addra=count and dia=tdata; count then increments.
- wea=0 on every cycle not following an accepted beat or a ZERO write.
REQ-022 Beat number num_taps with tlast=1 -> go to ZERO, or to DONE when num_taps equals 2^ADDR_W.
REQ-023 Beat number num_taps with tlast=0 -> the beat is written, err is set, go to DRAIN.
REQ-024 tlast on a beat numbered below num_taps -> the beat is written, err is set, go to ZERO.
REQ-025 DRAIN: s_axis_tready=1; beats are discarded with no writes; the beat carrying tlast -> go to ZERO, or to DONE when the count equals 2^ADDR_W.
REQ-026 ZERO: s_axis_tready=0; one zero word is written per cycle at addresses count through 2^ADDR_W-1.
- The wea/addra/dia timing SHALL match REQ-021.
- After the write to address 2^ADDR_W-1 is issued, go to DONE.
REQ-027 DONE: assert done for exactly one cycle, then go to IDLE.
- done SHALL rise on the cycle immediately after the final wea=1 cycle.
REQ-028 The address SHALL never exceed 2^ADDR_W-1.
- The count is ADDR_W+1 bits wide; addra takes its low ADDR_W bits.
REQ-029 Gaps in tvalid SHALL stall LOAD and DRAIN without any write or state change.
REQ-030 s_axis_tready SHALL be a registered output, or decoded directly from the state register.

Reset
REQ-031 When sync_reset=1 at a clock edge, the next state SHALL be IDLE, and all outputs SHALL be 0:
- s_axis_tready, wea, addra, dia, busy, done, err.
- The count is cleared.
REQ-032 A reset asserted mid-load SHALL abort the load immediately.
- No further writes are issued.
- The RAM contents already written are left as they are.

Verification
REQ-033 Nominal load (ADDR_W=7): start with num_taps=80, then 80 back-to-back beats (tlast on beat 80) ->
- 80 writes at addresses 0..79 carrying the beat data;
- then 48 zero writes at addresses 80..127;
- done pulses once, the cycle after the addra=127 write; err=0.
REQ-034 Early tlast: num_taps=80, tlast on beat 40 ->
- data written at addresses 0..39 and zeros at 40..127;
- err=1, and done pulses once.
REQ-035 Missing tlast: num_taps=80, 85 beats with tlast on beat 85 ->
- data written at addresses 0..79; beats 81..85 discarded with no writes;
- zeros written at 80..127; err=1.
REQ-036 Bad count: start with num_taps=0, and separately with num_taps=129 ->
- err=1, busy stays 0, no wea, no done;
- a following valid start clears err.
REQ-037 Backpressure and reset:
- random tvalid gaps on a 128-tap load -> exactly 128 writes, no ZERO phase, done pulses once;
- sync_reset asserted after beat 20 -> all outputs 0 on the next cycle, no further wea, state IDLE.

Source files
------------

// File: rtl/pfb_coef_loader.sv
// Coefficient loader for a polyphase filter bank: streams AXI-Stream beats into a
// 2^ADDR_W-deep RAM, zero-fills the unused tail and flags malformed streams.
module pfb_coef_loader #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 25
) (
    input  logic              clk,
    input  logic              sync_reset,
    input  logic              start,
    input  logic [ADDR_W:0]   num_taps,
    input  logic              s_axis_tvalid,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dia,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LAST_ADDR = DEPTH - 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_ZERO,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W:0]     taps_q, taps_d;
    logic                wea_q, wea_d;
    logic [ADDR_W-1:0]   addra_q, addra_d;
    logic [DATA_W-1:0]   dia_q, dia_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                beat;
    logic [ADDR_W:0]     beat_num;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            taps_q  <= '0;
            wea_q   <= 1'b0;
            addra_q <= '0;
            dia_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            taps_q  <= taps_d;
            wea_q   <= wea_d;
            addra_q <= addra_d;
            dia_q   <= dia_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign beat     = s_axis_tvalid && s_axis_tready;
    assign beat_num = count_q + 1'b1;

    // NOTE: every variable gets a default before the case statement so no
    // path leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        taps_d  = taps_q;
        wea_d   = 1'b0;
        addra_d = addra_q;
        dia_d   = dia_q;
        err_d   = err_q;
        // done is delayed a cycle so it follows the last visible write
        done_d  = (state_q == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_taps != '0 && num_taps <= DEPTH) begin
                        taps_d  = num_taps;
                        count_d = '0;
                        err_d   = 1'b0;
                        state_d = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (beat) begin
                    wea_d   = 1'b1;
                    addra_d = count_q[ADDR_W-1:0];
                    dia_d   = s_axis_tdata;
                    count_d = beat_num;
                    if (beat_num == taps_q) begin
                        if (s_axis_tlast) begin
                            state_d = (taps_q == DEPTH) ? S_DONE : S_ZERO;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_DRAIN;
                        end
                    end else if (s_axis_tlast) begin
                        err_d   = 1'b1;
                        state_d = S_ZERO;
                    end
                end
            end
            S_DRAIN: begin
                if (beat && s_axis_tlast) begin
                    state_d = (count_q == DEPTH) ? S_DONE : S_ZERO;
                end
            end
            S_ZERO: begin
                wea_d   = 1'b1;
                addra_d = count_q[ADDR_W-1:0];
                dia_d   = '0;
                count_d = count_q + 1'b1;
                if (count_q == LAST_ADDR) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign s_axis_tready = (state_q == S_LOAD) || (state_q == S_DRAIN);
    assign busy          = (state_q != S_IDLE);
    assign wea           = wea_q;
    assign addra         = addra_q;
    assign dia           = dia_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule
